// File: rtl/memory_stage.sv
// Memory pipeline stage: data-memory access, stack ops, multi-cycle PC save/restore
// for CALL/RET/RTI, OUT port, and the MEM/WB register that also feeds forwarding.
module memory_stage #(
  parameter int                ADDR_W  = 20,
  parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic [105:0]      In,
  input  logic [15:0]       MemRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [15:0]       MemWData,
  output logic              MemRd,
  output logic              MemWr,
  output logic              Stall,
  output logic [19:0]       Out,
  output logic              PcLoad,
  output logic [31:0]       PcTarget,
  output logic              FlagsLoad,
  output logic [2:0]        FlagsVal,
  output logic [15:0]       OutPort,
  output logic [ADDR_W-1:0] SpOut
);

  typedef enum logic [1:0] {IDLE, S2, S3} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_CALL, OP_RET, OP_RTI, OP_PUSH, OP_POP, OP_LDD, OP_STD} op_t;

  logic [15:0] in_port, rsrc_val, alu_res;
  logic [31:0] next_pc;
  logic [2:0]  rdst;
  logic        is_push, is_pop, is_ret, is_rti, is_ldd, is_in, is_out, is_call, is_memwr, is_wb;
  logic        unused_bits;

  assign in_port   = In[98:83];
  assign next_pc   = In[82:51];
  assign rsrc_val  = In[50:35];
  assign alu_res   = In[34:19];
  assign rdst      = In[15:13];
  assign is_push   = In[11];
  assign is_pop    = In[10];
  assign is_ret    = In[9];
  assign is_rti    = In[8];
  assign is_ldd    = In[7];
  assign is_in     = In[6];
  assign is_out    = In[5];
  assign is_call   = In[3];
  assign is_memwr  = In[1];
  assign is_wb     = In[0];
  assign unused_bits = ^{In[105:99], In[18:16], In[12], In[4], In[2]};

  state_t            state_q, state_d;
  op_t               op_sel;
  logic [ADDR_W-1:0] sp_q, sp_d;
  logic [15:0]       lo_q, lo_d, hi_q, hi_d;
  logic [19:0]       out_q, out_d;
  logic              pc_load_q, pc_load_d, flags_load_q, flags_load_d;
  logic [31:0]       pc_target_q, pc_target_d;
  logic [2:0]        flags_val_q, flags_val_d;
  logic [15:0]       out_port_q, out_port_d;
  logic              mem_rd, mem_wr;
  logic [15:0]       wb_data;

  always_comb begin
    op_sel = OP_NONE;
    if      (is_call)  op_sel = OP_CALL;
    else if (is_ret)   op_sel = OP_RET;
    else if (is_rti)   op_sel = OP_RTI;
    else if (is_push)  op_sel = OP_PUSH;
    else if (is_pop)   op_sel = OP_POP;
    else if (is_ldd)   op_sel = OP_LDD;
    else if (is_memwr) op_sel = OP_STD;
  end

  always_comb begin
    state_d      = state_q;
    sp_d         = sp_q;
    lo_d         = lo_q;
    hi_d         = hi_q;
    pc_load_d    = 1'b0;
    pc_target_d  = pc_target_q;
    flags_load_d = 1'b0;
    flags_val_d  = flags_val_q;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    MemAddr      = sp_q;
    MemWData     = rsrc_val;
    Stall        = 1'b0;
    wb_data      = is_in ? in_port : alu_res;

    case (op_sel)
      OP_CALL: begin
        mem_wr = 1'b1;
        if (state_q == IDLE) begin
          MemWData = next_pc[31:16];
          Stall    = 1'b1;
          state_d  = S2;
        end else begin
          MemAddr  = sp_q - ADDR_W'(1);
          MemWData = next_pc[15:0];
          sp_d     = sp_q - ADDR_W'(2);
          state_d  = IDLE;
        end
      end
      OP_RET: begin
        mem_rd = 1'b1;
        if (state_q == IDLE) begin
          MemAddr = sp_q + ADDR_W'(1);
          lo_d    = MemRData;
          Stall   = 1'b1;
          state_d = S2;
        end else begin
          MemAddr     = sp_q + ADDR_W'(2);
          sp_d        = sp_q + ADDR_W'(2);
          pc_target_d = {MemRData, lo_q};
          pc_load_d   = 1'b1;
          state_d     = IDLE;
        end
      end
      OP_RTI: begin
        mem_rd = 1'b1;
        case (state_q)
          IDLE: begin
            MemAddr = sp_q + ADDR_W'(1);
            lo_d    = MemRData;
            Stall   = 1'b1;
            state_d = S2;
          end
          S2: begin
            MemAddr = sp_q + ADDR_W'(2);
            hi_d    = MemRData;
            Stall   = 1'b1;
            state_d = S3;
          end
          default: begin
            MemAddr      = sp_q + ADDR_W'(3);
            flags_val_d  = MemRData[2:0];
            flags_load_d = 1'b1;
            pc_target_d  = {hi_q, lo_q};
            pc_load_d    = 1'b1;
            sp_d         = sp_q + ADDR_W'(3);
            state_d      = IDLE;
          end
        endcase
      end
      OP_PUSH: begin
        mem_wr = 1'b1;
        sp_d   = sp_q - ADDR_W'(1);
      end
      OP_POP: begin
        mem_rd  = 1'b1;
        MemAddr = sp_q + ADDR_W'(1);
        sp_d    = sp_q + ADDR_W'(1);
        wb_data = MemRData;
      end
      OP_LDD: begin
        mem_rd  = 1'b1;
        MemAddr = ADDR_W'(alu_res);
        wb_data = MemRData;
      end
      OP_STD: begin
        mem_wr  = 1'b1;
        MemAddr = ADDR_W'(alu_res);
      end
      default: state_d = IDLE;  // recover if In changed mid-sequence
    endcase

    out_d      = Stall ? 20'h0 : {is_wb, rdst, wb_data};
    out_port_d = (is_out && !Stall) ? alu_res : out_port_q;
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q      <= IDLE;
      sp_q         <= SP_INIT;
      lo_q         <= '0;
      hi_q         <= '0;
      out_q        <= '0;
      pc_load_q    <= 1'b0;
      pc_target_q  <= '0;
      flags_load_q <= 1'b0;
      flags_val_q  <= '0;
      out_port_q   <= '0;
    end else begin
      state_q      <= state_d;
      sp_q         <= sp_d;
      lo_q         <= lo_d;
      hi_q         <= hi_d;
      out_q        <= out_d;
      pc_load_q    <= pc_load_d;
      pc_target_q  <= pc_target_d;
      flags_load_q <= flags_load_d;
      flags_val_q  <= flags_val_d;
      out_port_q   <= out_port_d;
    end
  end

  // Strobes are masked in reset so an aborted sequence never touches memory.
  assign MemRd     = mem_rd & ~Reset;
  assign MemWr     = mem_wr & ~Reset;
  assign Out       = out_q;
  assign PcLoad    = pc_load_q;
  assign PcTarget  = pc_target_q;
  assign FlagsLoad = flags_load_q;
  assign FlagsVal  = flags_val_q;
  assign OutPort   = out_port_q;
  assign SpOut     = sp_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stack, CALL/RET/RTI sequencing, write-back mux,
// SP wrap-around and reset during a CALL, against hand-computed values.
module tb_memory_stage;

  localparam logic [12:0] C_PUSH = 13'h0800, C_POP = 13'h0400, C_RET = 13'h0200,
                          C_RTI  = 13'h0100, C_LDD = 13'h0080, C_IN  = 13'h0040,
                          C_OUT  = 13'h0020, C_CALL = 13'h0008, C_MRD = 13'h0004,
                          C_MWR  = 13'h0002, C_WB  = 13'h0001;

  logic         CLK = 1'b0;
  logic         Reset;
  logic [105:0] In;
  logic [15:0]  MemRData;
  logic [19:0]  MemAddr;
  logic [15:0]  MemWData;
  logic         MemRd, MemWr, Stall, PcLoad, FlagsLoad;
  logic [19:0]  Out;
  logic [31:0]  PcTarget;
  logic [2:0]   FlagsVal;
  logic [15:0]  OutPort;
  logic [19:0]  SpOut;

  int errors = 0;
  int checks = 0;

  // Every address touched maps to a distinct low-6-bit index.
  logic [15:0] mem [0:63];
  assign MemRData = mem[MemAddr[5:0]];
  always @(posedge CLK) if (MemWr && !Reset) mem[MemAddr[5:0]] <= MemWData;

  always #5 CLK = ~CLK;

  memory_stage dut (
    .CLK(CLK), .Reset(Reset), .In(In), .MemRData(MemRData), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemRd(MemRd), .MemWr(MemWr), .Stall(Stall), .Out(Out),
    .PcLoad(PcLoad), .PcTarget(PcTarget), .FlagsLoad(FlagsLoad), .FlagsVal(FlagsVal),
    .OutPort(OutPort), .SpOut(SpOut)
  );

  function automatic logic [105:0] mk(input logic [12:0] ctl, input logic [2:0] rdst,
                                      input logic [15:0] rsrc, input logic [15:0] alu,
                                      input logic [31:0] npc, input logic [15:0] inp);
    mk = '0;
    mk[98:83] = inp;
    mk[82:51] = npc;
    mk[50:35] = rsrc;
    mk[34:19] = alu;
    mk[15:13] = rdst;
    mk[12:0]  = ctl;
  endfunction

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [105:0] v);
    In = v;
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    In = '0;
    repeat (2) cyc();
    checks++; if (Out !== 20'h0) begin errors++; $display("FAIL rst_out got=%h exp=%h", Out, 20'h0); end
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL rst_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
    checks++; if ({PcLoad, FlagsLoad, Stall} !== 3'b000) begin errors++; $display("FAIL rst_pulses got=%b exp=000", {PcLoad, FlagsLoad, Stall}); end
    checks++; if ({PcTarget, FlagsVal, OutPort} !== 51'h0) begin errors++; $display("FAIL rst_regs got=%h/%h/%h exp=0", PcTarget, FlagsVal, OutPort); end
    Reset = 1'b0;
  endtask

  task automatic test_push_pop();
    drive(mk(C_PUSH | C_MWR, 3'd0, 16'h1234, 16'h0, 32'h0, 16'h0));
    checks++; if ({MemWr, MemAddr, MemWData} !== {1'b1, 20'hFFFFF, 16'h1234})
      begin errors++; $display("FAIL push_bus got=%b/%h/%h exp=1/fffff/1234", MemWr, MemAddr, MemWData); end
    cyc();
    checks++; if (SpOut !== 20'hFFFFE) begin errors++; $display("FAIL push_sp got=%h exp=%h", SpOut, 20'hFFFFE); end
    drive(mk(C_POP | C_MRD | C_WB, 3'd3, 16'h0, 16'h0, 32'h0, 16'h0));
    checks++; if ({MemRd, MemAddr} !== {1'b1, 20'hFFFFF}) begin errors++; $display("FAIL pop_addr got=%b/%h exp=1/fffff", MemRd, MemAddr); end
    cyc();
    checks++; if (Out !== 20'hB1234) begin errors++; $display("FAIL pop_out got=%h exp=%h", Out, 20'hB1234); end
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL pop_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
  endtask

  task automatic test_call_ret();
    drive(mk(C_CALL, 3'd0, 16'h0, 16'h0, 32'h0001_0040, 16'h0));
    checks++; if ({MemWr, MemAddr, MemWData, Stall} !== {1'b1, 20'hFFFFF, 16'h0001, 1'b1})
      begin errors++; $display("FAIL call0 got=%b/%h/%h/%b exp=1/fffff/0001/1", MemWr, MemAddr, MemWData, Stall); end
    cyc();
    checks++; if (Out !== 20'h0) begin errors++; $display("FAIL call_bubble got=%h exp=0", Out); end
    checks++; if ({MemWr, MemAddr, MemWData, Stall} !== {1'b1, 20'hFFFFE, 16'h0040, 1'b0})
      begin errors++; $display("FAIL call1 got=%b/%h/%h/%b exp=1/ffffe/0040/0", MemWr, MemAddr, MemWData, Stall); end
    cyc();
    checks++; if (SpOut !== 20'hFFFFD) begin errors++; $display("FAIL call_sp got=%h exp=%h", SpOut, 20'hFFFFD); end
    drive(mk(C_RET, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0));
    checks++; if ({MemRd, MemAddr, Stall} !== {1'b1, 20'hFFFFE, 1'b1}) begin errors++; $display("FAIL ret0 got=%b/%h/%b exp=1/ffffe/1", MemRd, MemAddr, Stall); end
    cyc();
    checks++; if ({MemRd, MemAddr, Stall, PcLoad} !== {1'b1, 20'hFFFFF, 1'b0, 1'b0}) begin errors++; $display("FAIL ret1 got=%b/%h/%b/%b exp=1/fffff/0/0", MemRd, MemAddr, Stall, PcLoad); end
    cyc();
    checks++; if ({PcLoad, PcTarget} !== {1'b1, 32'h0001_0040}) begin errors++; $display("FAIL ret_pc got=%b/%h exp=1/00010040", PcLoad, PcTarget); end
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL ret_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
    drive('0);
    cyc();
    checks++; if (PcLoad !== 1'b0) begin errors++; $display("FAIL ret_pulse got=%b exp=0", PcLoad); end
  endtask

  task automatic test_rti();
    logic [15:0] vals [3];
    vals[0] = 16'h0005; vals[1] = 16'h0001; vals[2] = 16'h0040;
    for (int i = 0; i < 3; i++) begin
      drive(mk(C_PUSH | C_MWR, 3'd0, vals[i], 16'h0, 32'h0, 16'h0));
      cyc();
    end
    checks++; if (SpOut !== 20'hFFFFC) begin errors++; $display("FAIL rti_pre_sp got=%h exp=%h", SpOut, 20'hFFFFC); end
    drive(mk(C_RTI, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0));
    checks++; if ({Stall, MemAddr} !== {1'b1, 20'hFFFFD}) begin errors++; $display("FAIL rti0 got=%b/%h exp=1/ffffd", Stall, MemAddr); end
    cyc();
    checks++; if ({Stall, MemAddr} !== {1'b1, 20'hFFFFE}) begin errors++; $display("FAIL rti1 got=%b/%h exp=1/ffffe", Stall, MemAddr); end
    cyc();
    checks++; if ({Stall, MemAddr, PcLoad} !== {1'b0, 20'hFFFFF, 1'b0}) begin errors++; $display("FAIL rti2 got=%b/%h/%b exp=0/fffff/0", Stall, MemAddr, PcLoad); end
    cyc();
    checks++; if ({PcLoad, FlagsLoad, PcTarget, FlagsVal} !== {1'b1, 1'b1, 32'h0001_0040, 3'b101})
      begin errors++; $display("FAIL rti_load got=%b/%b/%h/%b exp=1/1/00010040/101", PcLoad, FlagsLoad, PcTarget, FlagsVal); end
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL rti_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
    drive('0);
    cyc();
    checks++; if ({PcLoad, FlagsLoad} !== 2'b00) begin errors++; $display("FAIL rti_pulse got=%b exp=00", {PcLoad, FlagsLoad}); end
  endtask

  task automatic test_wb_mux();
    drive(mk(C_MWR, 3'd0, 16'hBEEF, 16'h0010, 32'h0, 16'h0));
    checks++; if ({MemWr, MemAddr} !== {1'b1, 20'h00010}) begin errors++; $display("FAIL std_addr got=%b/%h exp=1/00010", MemWr, MemAddr); end
    cyc();
    drive(mk(C_LDD | C_MRD | C_WB, 3'd5, 16'h0, 16'h0010, 32'h0, 16'h0));
    cyc();
    checks++; if (Out !== 20'hDBEEF) begin errors++; $display("FAIL ldd_out got=%h exp=%h", Out, 20'hDBEEF); end
    drive(mk(C_MWR, 3'd0, 16'hCAFE, 16'h0011, 32'h0, 16'h0));
    cyc();
    checks++; if (Out[19] !== 1'b0) begin errors++; $display("FAIL std_wb got=%b exp=0", Out[19]); end
    checks++; if (mem[6'h11] !== 16'hCAFE) begin errors++; $display("FAIL std_mem got=%h exp=%h", mem[6'h11], 16'hCAFE); end
    drive(mk(C_LDD | C_MRD | C_WB, 3'd2, 16'h0, 16'h0011, 32'h0, 16'h0));
    cyc();
    checks++; if (Out !== 20'hACAFE) begin errors++; $display("FAIL ldd2_out got=%h exp=%h", Out, 20'hACAFE); end
    drive(mk(C_IN | C_WB, 3'd1, 16'h0, 16'h7777, 32'h0, 16'h00AA));
    cyc();
    checks++; if (Out !== 20'h900AA) begin errors++; $display("FAIL in_out got=%h exp=%h", Out, 20'h900AA); end
    drive(mk(C_OUT, 3'd0, 16'h0, 16'h5555, 32'h0, 16'h0));
    checks++; if ({MemRd, MemWr} !== 2'b00) begin errors++; $display("FAIL out_strobes got=%b exp=00", {MemRd, MemWr}); end
    cyc();
    checks++; if (OutPort !== 16'h5555) begin errors++; $display("FAIL outport got=%h exp=%h", OutPort, 16'h5555); end
    drive(mk(C_WB, 3'd7, 16'h0, 16'h1357, 32'h0, 16'h0));
    cyc();
    checks++; if (Out !== 20'hF1357) begin errors++; $display("FAIL alu_out got=%h exp=%h", Out, 20'hF1357); end
    checks++; if (OutPort !== 16'h5555) begin errors++; $display("FAIL outport_hold got=%h exp=%h", OutPort, 16'h5555); end
  endtask

  task automatic test_wrap();
    drive(mk(C_POP | C_MRD, 3'd0, 16'h0, 16'h0, 32'h0, 16'h0));
    checks++; if (MemAddr !== 20'h00000) begin errors++; $display("FAIL wrap_pop_addr got=%h exp=00000", MemAddr); end
    cyc();
    checks++; if (SpOut !== 20'h00000) begin errors++; $display("FAIL wrap_pop_sp got=%h exp=00000", SpOut); end
    drive(mk(C_PUSH | C_MWR, 3'd0, 16'h7777, 16'h0, 32'h0, 16'h0));
    checks++; if ({MemWr, MemAddr} !== {1'b1, 20'h00000}) begin errors++; $display("FAIL wrap_push_addr got=%b/%h exp=1/00000", MemWr, MemAddr); end
    cyc();
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL wrap_push_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
    drive(mk(C_POP | C_MRD | C_WB, 3'd4, 16'h0, 16'h0, 32'h0, 16'h0));
    cyc();
    checks++; if (Out !== 20'hC7777) begin errors++; $display("FAIL wrap_pop_out got=%h exp=%h", Out, 20'hC7777); end
  endtask

  task automatic test_reset_mid_call();
    // SP is 0 here, so a completed CALL would write index 0x3F (currently 0x0005).
    drive(mk(C_CALL, 3'd0, 16'h0, 16'h0, 32'hABCD_1234, 16'h0));
    cyc();
    Reset = 1'b1;
    #1;
    checks++; if (MemWr !== 1'b0) begin errors++; $display("FAIL midcall_memwr got=%b exp=0", MemWr); end
    cyc();
    Reset = 1'b0;
    drive('0);
    checks++; if (mem[6'h3F] !== 16'h0005) begin errors++; $display("FAIL midcall_mem got=%h exp=%h", mem[6'h3F], 16'h0005); end
    checks++; if ({Stall, PcLoad} !== 2'b00) begin errors++; $display("FAIL midcall_stall got=%b exp=00", {Stall, PcLoad}); end
    checks++; if (SpOut !== 20'hFFFFF) begin errors++; $display("FAIL midcall_sp got=%h exp=%h", SpOut, 20'hFFFFF); end
    checks++; if (Out !== 20'h0) begin errors++; $display("FAIL midcall_out got=%h exp=0", Out); end
    drive(mk(C_PUSH | C_MWR, 3'd0, 16'h4242, 16'h0, 32'h0, 16'h0));
    checks++; if ({MemAddr, Stall} !== {20'hFFFFF, 1'b0}) begin errors++; $display("FAIL midcall_idle got=%h/%b exp=fffff/0", MemAddr, Stall); end
    cyc();
    drive('0);
  endtask

  initial begin
    Reset = 1'b1;
    In = '0;
    test_reset();
    test_push_pop();
    test_call_ret();
    test_rti();
    test_wb_mux();
    test_wrap();
    test_reset_mid_call();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline stage directly downstream of execute: consumes execute's 106-bit output bundle and performs data-memory access (LDD/STD), stack operations (PUSH/POP), and 32-bit program-counter save/restore (CALL/RET/RTI) using a stack-pointer register and a multi-cycle sequencer. It also drives the OUT port and registers the write-back bundle (MEM/WB register). That bundle is fed back as the memory-stage forwarding input of execute. While a multi-cycle operation is in progress, it stalls upstream.

## Interface
- ADDR_W, 20, data-memory word-address width; SP width.
- SP_INIT, 20'hFFFFF, stack-pointer reset value.

- CLK  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high.
- In  in  106  execute bundle:
  - [105:103] CF/NF/ZF; [102:99] JMP/JC/JN/JZ (unused here).
  - [98:83] InPort; [82:51] next-PC; [50:35] Rsrc value; [34:19] ALU result; [18:16] Rsrc addr; [15:13] Rdst addr.
  - [12] prev-stack-op; [11] PUSH; [10] POP; [9] RET; [8] RTI; [7] LDD; [6] IN; [5] OUT; [4] 2nd-iter; [3] CALL; [2] MemRead; [1] MemWrite; [0] WB.
- MemRData  in  16  data-memory read word; combinational (asynchronous) read.
- MemAddr  out  ADDR_W  data-memory word address (combinational).
- MemWData  out  16  write data (combinational).
- MemRd / MemWr  out  1  read / write strobes (combinational); memory writes on the CLK edge.
- Stall  out  1  combinational; high means execute must hold In stable next cycle.
- Out  out  20  registered {WB, Rdst addr[2:0], data[15:0]}; also execute Fwd[19:0].
- PcLoad  out  1  registered one-cycle pulse: redirect fetch.
- PcTarget  out  32  restored PC, valid with PcLoad.
- FlagsLoad  out  1  registered one-cycle pulse (RTI only).
- FlagsVal  out  3  {CF,NF,ZF} restored by RTI.
- OutPort  out  16  output-port register.
- SpOut  out  ADDR_W  current SP (debug/verification).

## Operation
- Operation select uses fixed priority: CALL > RET > RTI > PUSH > POP > LDD > MemWrite (STD) > none.
- The stack grows downward; SP points at the next free word. All SP arithmetic is modulo 2^ADDR_W and wraps silently.
- **PUSH:** write mem[SP] = Rsrc value; SP <= SP-1.
- **POP:** read mem[SP+1]; SP <= SP+1; write-back data = MemRData.
- **LDD:** read mem[ALU[ADDR_W-1:0]]; write-back data = MemRData.
- **STD:** write mem[ALU] = Rsrc value.
- **IN:** write-back data = InPort.
- **OUT:** OutPort <= ALU result.
- **Other ops:** write-back data = ALU result.
- FSM states: IDLE, S2, S3.
- **CALL:**
  - IDLE: write mem[SP] = next-PC[31:16]; Stall=1; go to S2.
  - S2: write mem[SP-1] = next-PC[15:0]; SP <= SP-2; go to IDLE.
- **RET:**
  - IDLE: read mem[SP+1], latch as lo; Stall=1; go to S2.
  - S2: read mem[SP+2]; SP <= SP+2; PcTarget <= {MemRData, lo}; PcLoad <= 1; go to IDLE.
- **RTI:**
  - IDLE: read lo; go to S2.
  - S2: read hi, latch; go to S3.
  - S3: read mem[SP+3]; FlagsVal <= MemRData[2:0]; FlagsLoad <= 1; PcTarget <= {hi, lo}; PcLoad <= 1; SP <= SP+3; go to IDLE.
  - Stall=1 in IDLE and S2.
- Stall is high in every cycle of a multi-cycle op except its last.
- Out write-back register:
  - Loaded only in the last cycle of an op.
  - During Stall cycles it loads {0, 000, 0000} (bubble).
  - WB bit copied from In[0]; Rdst from In[15:13].
- MemRd/MemWr are 0 when no memory op is selected; MemAddr/MemWData are then don't-care.

## Timing
- Out, PcLoad, PcTarget, FlagsLoad, FlagsVal, OutPort, SP all update on the CLK edge: one-cycle latency from the accepting cycle.
- PcLoad/FlagsLoad are single-cycle pulses; otherwise 0.
- Latency per op: CALL/RET = 2 cycles; RTI = 3 cycles; all others = 1 cycle.
- Reset, including mid-operation:
  - State = IDLE; SP = SP_INIT; Out = 0; PcLoad = FlagsLoad = 0.
  - PcTarget = 0; FlagsVal = 0; OutPort = 0.
  - Latched lo/hi words are discarded. No PcLoad is issued for an aborted RET/RTI; a partial CALL leaves SP unchanged.
- Memory writes happen on the CLK edge only, while MemWr is high and Reset is low.

## Test plan
- **Reset, PUSH then POP:** PUSH Rsrc=0x1234 → MemWr, MemAddr=FFFFF, MemWData=0x1234, SP=FFFFE. Then POP with WB=1, Rdst=3 → MemAddr=FFFFF; next cycle Out={1,3,0x1234} and SP=FFFFF.
- **CALL then RET:** CALL with next-PC=0x00010040 → cycle0 writes FFFFF=0x0001 with Stall=1; cycle1 writes FFFFE=0x0040 with Stall=0; SP=FFFFD. RET → reads FFFFE then FFFFF; next cycle PcLoad=1, PcTarget=0x00010040, SP=FFFFF.
- **RTI:** memory preloaded FFFFD=0x0040, FFFFE=0x0001, FFFFF=0x0005, SP=FFFFC. RTI → Stall=1,1,0; then PcTarget=0x00010040, FlagsVal=3'b101, SP=FFFFF.
- **Write-back mux:**
  - LDD with ALU=0x0010, mem=0xBEEF → Out data=0xBEEF.
  - STD with ALU=0x0011, Rsrc=0xCAFE → mem[0x0011]=0xCAFE with Out WB=0.
  - IN with InPort=0x00AA → Out data=0x00AA.
  - OUT with ALU=0x5555 → OutPort=0x5555.
- **Wrap-around:** SP=0x00000, PUSH → write at 0, SP=FFFFF. POP at SP=FFFFF → reads address 0.
- **Reset mid-CALL:** Reset asserted in S2 → no write in that cycle, SP=FFFFF, state IDLE, Stall=0, Out=0.
